// File: rtl/mipi_csi_pkg.sv
// rtl/mipi_csi_pkg.sv - shared CSI-2 constants for the receive and transmit packet paths
//
// Purpose: data type codes, packet header field positions and the decoder
//          FSM state encodings, shared by the CSI-2 RX and TX blocks.
// Ports:   none (package).

package mipi_csi_pkg;

    // Data type codes (DI[5:0])
    localparam logic [5:0] DT_FS        = 6'h00;
    localparam logic [5:0] DT_FE        = 6'h01;
    localparam logic [5:0] DT_LS        = 6'h02;
    localparam logic [5:0] DT_LE        = 6'h03;
    localparam logic [5:0] DT_SHORT_MAX = 6'h0F;
    localparam logic [5:0] DT_RAW8      = 6'h2A;
    localparam logic [5:0] DT_RAW10     = 6'h2B;

    // Packet header field offsets within the first 32-bit word of a burst
    localparam int HDR_DT_LSB  = 0;
    localparam int HDR_DT_W    = 6;
    localparam int HDR_VC_LSB  = 6;
    localparam int HDR_VC_W    = 2;
    localparam int HDR_WC_LSB  = 8;
    localparam int HDR_WC_W    = 16;
    localparam int HDR_ECC_LSB = 24;
    localparam int HDR_ECC_W   = 6;
    localparam int HDR_DATA_W  = 24;

    // Decoder FSM states
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;

endpackage

// File: rtl/mipi_csi_header_ecc.sv
// rtl/mipi_csi_header_ecc.sv - CSI-2 packet header 6-bit Hamming parity and syndrome
//
// Purpose: combinational parity over the 24 header bits (DI + WC) and the
//          syndrome against a received ECC byte. Tying ecc_i to zero makes
//          syndrome_o equal the parity, which is how a transmitter uses it.
// Ports:
//   data_i     [23:0] header bits, DI in [7:0], WC in [23:8]
//   ecc_i      [5:0]  received ECC bits
//   syndrome_o [5:0]  computed parity XOR ecc_i; zero means header intact

module mipi_csi_header_ecc (
    input  logic [23:0] data_i,
    input  logic [5:0]  ecc_i,
    output logic [5:0]  syndrome_o
);

    logic [5:0] w_parity;

    always_comb begin
        w_parity[0] = data_i[0]  ^ data_i[1]  ^ data_i[2]  ^ data_i[4]  ^ data_i[5]  ^
                      data_i[7]  ^ data_i[10] ^ data_i[11] ^ data_i[13] ^ data_i[16] ^
                      data_i[20] ^ data_i[21] ^ data_i[22] ^ data_i[23];
        w_parity[1] = data_i[0]  ^ data_i[1]  ^ data_i[3]  ^ data_i[4]  ^ data_i[6]  ^
                      data_i[8]  ^ data_i[10] ^ data_i[12] ^ data_i[14] ^ data_i[17] ^
                      data_i[20] ^ data_i[21] ^ data_i[22] ^ data_i[23];
        w_parity[2] = data_i[0]  ^ data_i[2]  ^ data_i[3]  ^ data_i[5]  ^ data_i[6]  ^
                      data_i[9]  ^ data_i[11] ^ data_i[12] ^ data_i[15] ^ data_i[18] ^
                      data_i[20] ^ data_i[21] ^ data_i[22];
        w_parity[3] = data_i[1]  ^ data_i[2]  ^ data_i[3]  ^ data_i[7]  ^ data_i[8]  ^
                      data_i[9]  ^ data_i[13] ^ data_i[14] ^ data_i[15] ^ data_i[19] ^
                      data_i[20] ^ data_i[21] ^ data_i[23];
        w_parity[4] = data_i[4]  ^ data_i[5]  ^ data_i[6]  ^ data_i[7]  ^ data_i[8]  ^
                      data_i[9]  ^ data_i[16] ^ data_i[17] ^ data_i[18] ^ data_i[19] ^
                      data_i[20] ^ data_i[22] ^ data_i[23];
        w_parity[5] = data_i[10] ^ data_i[11] ^ data_i[12] ^ data_i[13] ^ data_i[14] ^
                      data_i[15] ^ data_i[16] ^ data_i[17] ^ data_i[18] ^ data_i[19] ^
                      data_i[21] ^ data_i[22] ^ data_i[23];
    end

    assign syndrome_o = w_parity ^ ecc_i;

endmodule

// File: rtl/mipi_rx_packet_decoder.sv
// rtl/mipi_rx_packet_decoder.sv - CSI-2 receive packet decoder for a 4-lane aligned byte stream
//
// Purpose: parses the packet header on the first valid word of each burst,
//          strips header and CRC, emits long-packet payload with byte enables
//          and turns short packets into frame/line sync pulses.
// Ports:
//   clk_i              MIPI byte clock
//   reset_i            asynchronous active-high reset
//   lane_valid_i       aligned data valid for the whole burst
//   lane_byte_i [31:0] aligned bytes, [7:0] = lane0 = earliest byte
//   payload_o   [31:0] payload word, same byte order as input
//   payload_valid_o    payload_o valid
//   payload_be_o [3:0] byte enables for payload_o
//   data_type_o  [5:0] DT of current/last packet
//   virtual_channel_o [1:0] VC of current/last packet
//   word_count_o [15:0] WC of current/last packet
//   packet_done_o      pulse: long-packet payload complete
//   frame_start_o, frame_end_o, line_start_o, line_end_o  sync pulses
//   ecc_err_o          pulse: header rejected
//   trunc_err_o        pulse: burst ended before WC bytes arrived

module mipi_rx_packet_decoder
    import mipi_csi_pkg::*;
#(
    parameter int LANES     = 4,
    parameter bit CHECK_ECC = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        lane_valid_i,
    input  logic [31:0] lane_byte_i,
    output logic [31:0] payload_o,
    output logic        payload_valid_o,
    output logic [3:0]  payload_be_o,
    output logic [5:0]  data_type_o,
    output logic [1:0]  virtual_channel_o,
    output logic [15:0] word_count_o,
    output logic        packet_done_o,
    output logic        frame_start_o,
    output logic        frame_end_o,
    output logic        line_start_o,
    output logic        line_end_o,
    output logic        ecc_err_o,
    output logic        trunc_err_o
);

    localparam logic [15:0] BYTES_PER_WORD = 16'(LANES);

    logic [1:0]  r_state;
    logic [15:0] r_remaining;

    logic [5:0]  w_syndrome;
    logic [5:0]  w_dt;
    logic [1:0]  w_vc;
    logic [15:0] w_wc;
    logic        w_hdr_bad;
    logic [3:0]  w_last_be;

    mipi_csi_header_ecc u_hdr_ecc (
        .data_i     (lane_byte_i[HDR_DATA_W-1:0]),
        .ecc_i      (lane_byte_i[HDR_ECC_LSB +: HDR_ECC_W]),
        .syndrome_o (w_syndrome)
    );

    assign w_dt      = lane_byte_i[HDR_DT_LSB +: HDR_DT_W];
    assign w_vc      = lane_byte_i[HDR_VC_LSB +: HDR_VC_W];
    assign w_wc      = lane_byte_i[HDR_WC_LSB +: HDR_WC_W];
    assign w_hdr_bad = CHECK_ECC && (w_syndrome != 6'd0);

    // Enables for the final word; only reached with 1..4 bytes left.
    always_comb begin
        w_last_be = 4'hF;
        case (r_remaining[2:0])
            3'd1:    w_last_be = 4'h1;
            3'd2:    w_last_be = 4'h3;
            3'd3:    w_last_be = 4'h7;
            default: w_last_be = 4'hF;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state           <= ST_IDLE;
            r_remaining       <= 16'd0;
            payload_o         <= 32'd0;
            payload_valid_o   <= 1'b0;
            payload_be_o      <= 4'd0;
            data_type_o       <= 6'd0;
            virtual_channel_o <= 2'd0;
            word_count_o      <= 16'd0;
            packet_done_o     <= 1'b0;
            frame_start_o     <= 1'b0;
            frame_end_o       <= 1'b0;
            line_start_o      <= 1'b0;
            line_end_o        <= 1'b0;
            ecc_err_o         <= 1'b0;
            trunc_err_o       <= 1'b0;
        end else begin
            // Pulses and payload strobes last exactly one cycle.
            payload_o       <= 32'd0;
            payload_valid_o <= 1'b0;
            payload_be_o    <= 4'd0;
            packet_done_o   <= 1'b0;
            frame_start_o   <= 1'b0;
            frame_end_o     <= 1'b0;
            line_start_o    <= 1'b0;
            line_end_o      <= 1'b0;
            ecc_err_o       <= 1'b0;
            trunc_err_o     <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (lane_valid_i) begin
                        // Header fields are latched even when the header is rejected.
                        data_type_o       <= w_dt;
                        virtual_channel_o <= w_vc;
                        word_count_o      <= w_wc;
                        if (w_hdr_bad) begin
                            ecc_err_o <= 1'b1;
                            r_state   <= ST_DRAIN;
                        end else if (w_dt <= DT_SHORT_MAX) begin
                            frame_start_o <= (w_dt == DT_FS);
                            frame_end_o   <= (w_dt == DT_FE);
                            line_start_o  <= (w_dt == DT_LS);
                            line_end_o    <= (w_dt == DT_LE);
                            r_state       <= ST_DRAIN;
                        end else if (w_wc == 16'd0) begin
                            packet_done_o <= 1'b1;
                            r_state       <= ST_DRAIN;
                        end else begin
                            r_remaining <= w_wc;
                            r_state     <= ST_PAYLOAD;
                        end
                    end
                end

                ST_PAYLOAD: begin
                    if (lane_valid_i) begin
                        payload_o       <= lane_byte_i;
                        payload_valid_o <= 1'b1;
                        if (r_remaining > BYTES_PER_WORD) begin
                            payload_be_o <= 4'hF;
                            r_remaining  <= r_remaining - BYTES_PER_WORD;
                        end else begin
                            payload_be_o  <= w_last_be;
                            packet_done_o <= 1'b1;
                            r_remaining   <= 16'd0;
                            r_state       <= ST_DRAIN;
                        end
                    end else begin
                        trunc_err_o <= 1'b1;
                        r_remaining <= 16'd0;
                        r_state     <= ST_IDLE;
                    end
                end

                ST_DRAIN: begin
                    if (!lane_valid_i) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mipi_rx_packet_decoder.sv
// tb/tb_mipi_rx_packet_decoder.sv - scoreboard bench for mipi_rx_packet_decoder

module tb_mipi_rx_packet_decoder;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  be;
        logic        pv;
        logic        done;
        logic        fs;
        logic        fe;
        logic        ls;
        logic        le;
        logic        ecc;
        logic        trunc;
        logic [5:0]  dt;
        logic [1:0]  vc;
        logic [15:0] wc;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        lv;
    logic [31:0] lb;

    logic [31:0] a_pay,  b_pay;
    logic        a_pv,   b_pv;
    logic [3:0]  a_be,   b_be;
    logic [5:0]  a_dt,   b_dt;
    logic [1:0]  a_vc,   b_vc;
    logic [15:0] a_wc,   b_wc;
    logic        a_done, b_done;
    logic        a_fs,   b_fs;
    logic        a_fe,   b_fe;
    logic        a_ls,   b_ls;
    logic        a_le,   b_le;
    logic        a_ecc,  b_ecc;
    logic        a_tr,   b_tr;

    ev_t a_act, b_act;
    ev_t qa[$];
    ev_t qb[$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mipi_rx_packet_decoder #(.LANES(4), .CHECK_ECC(1'b1)) dut (
        .clk_i (clk), .reset_i (rst), .lane_valid_i (lv), .lane_byte_i (lb),
        .payload_o (a_pay), .payload_valid_o (a_pv), .payload_be_o (a_be),
        .data_type_o (a_dt), .virtual_channel_o (a_vc), .word_count_o (a_wc),
        .packet_done_o (a_done), .frame_start_o (a_fs), .frame_end_o (a_fe),
        .line_start_o (a_ls), .line_end_o (a_le), .ecc_err_o (a_ecc),
        .trunc_err_o (a_tr)
    );

    mipi_rx_packet_decoder #(.LANES(4), .CHECK_ECC(1'b0)) dut_noecc (
        .clk_i (clk), .reset_i (rst), .lane_valid_i (lv), .lane_byte_i (lb),
        .payload_o (b_pay), .payload_valid_o (b_pv), .payload_be_o (b_be),
        .data_type_o (b_dt), .virtual_channel_o (b_vc), .word_count_o (b_wc),
        .packet_done_o (b_done), .frame_start_o (b_fs), .frame_end_o (b_fe),
        .line_start_o (b_ls), .line_end_o (b_le), .ecc_err_o (b_ecc),
        .trunc_err_o (b_tr)
    );

    assign a_act = {a_pay, a_be, a_pv, a_done, a_fs, a_fe, a_ls, a_le, a_ecc, a_tr, a_dt, a_vc, a_wc};
    assign b_act = {b_pay, b_be, b_pv, b_done, b_fs, b_fe, b_ls, b_le, b_ecc, b_tr, b_dt, b_vc, b_wc};

    // Column of the CSI-2 ECC generator matrix for each header data bit.
    function automatic logic [5:0] ecc_col(input int i);
        case (i)
            0: return 6'h07;  1: return 6'h0B;  2: return 6'h0D;  3: return 6'h0E;
            4: return 6'h13;  5: return 6'h15;  6: return 6'h16;  7: return 6'h19;
            8: return 6'h1A;  9: return 6'h1C; 10: return 6'h23; 11: return 6'h25;
           12: return 6'h26; 13: return 6'h29; 14: return 6'h2A; 15: return 6'h2C;
           16: return 6'h31; 17: return 6'h32; 18: return 6'h34; 19: return 6'h38;
           20: return 6'h1F; 21: return 6'h2F; 22: return 6'h37; 23: return 6'h3B;
           default: return 6'h00;
        endcase
    endfunction

    function automatic logic [31:0] hdr(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc);
        logic [23:0] d;
        logic [5:0]  p;
        d = {wc, vc, dt};
        p = 6'd0;
        for (int i = 0; i < 24; i++) begin
            if (d[i]) p = p ^ ecc_col(i);
        end
        return {2'b00, p, d};
    endfunction

    function automatic ev_t ev_base(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc);
        ev_t e;
        e    = '0;
        e.dt = dt;
        e.vc = vc;
        e.wc = wc;
        return e;
    endfunction

    function automatic ev_t ev_pay(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                                   input logic [31:0] data, input logic [3:0] be, input logic done);
        ev_t e;
        e      = ev_base(vc, dt, wc);
        e.data = data;
        e.be   = be;
        e.pv   = 1'b1;
        e.done = done;
        return e;
    endfunction

    function automatic logic any_ev(input ev_t x);
        return x.pv | x.done | x.fs | x.fe | x.ls | x.le | x.ecc | x.trunc;
    endfunction

    task automatic cmp(input string name, input ev_t act, input ev_t exp);
        ev_t m;
        m = act;
        if (!m.pv) m.data = 32'd0;
        n_tests++;
        if (m !== exp) begin
            n_fail++;
            $display("FAIL %s event: got %h expected %h", name, m, exp);
        end
    endtask

    task automatic push2(input ev_t e);
        qa.push_back(e);
        qb.push_back(e);
    endtask

    task automatic drive(input logic v, input logic [31:0] d);
        @(negedge clk);
        lv = v;
        lb = d;
    endtask

    task automatic chk_all_zero(input string name);
        n_tests++;
        if (a_act !== '0 || b_act !== '0) begin
            n_fail++;
            $display("FAIL %s: outputs got %h / %h expected all zero", name, a_act, b_act);
        end
    endtask

    // Monitors: every cycle in which a DUT presents an output is matched against its queue.
    always @(negedge clk) begin
        if (!rst && any_ev(a_act)) begin
            if (qa.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_A: got %h expected no output", a_act);
            end else begin
                cmp("chk_ecc_on", a_act, qa.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && any_ev(b_act)) begin
            if (qb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_B: got %h expected no output", b_act);
            end else begin
                cmp("chk_ecc_off", b_act, qb.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] h;
        rst = 1'b1;
        lv  = 1'b0;
        lb  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset_state");
        @(negedge clk);
        rst = 1'b0;

        // FS, VC=1, WC=5; header ECC 0x2F worked out by hand.
        push2('{data: 32'd0, be: 4'd0, pv: 1'b0, done: 1'b0, fs: 1'b1, fe: 1'b0, ls: 1'b0, le: 1'b0,
                ecc: 1'b0, trunc: 1'b0, dt: 6'h00, vc: 2'd1, wc: 16'h0005});
        drive(1'b1, 32'h2F00_0540);
        drive(1'b1, 32'h1234_5678);
        drive(1'b0, 32'd0);

        // FE, LS, LE short packets
        begin ev_t e; e = ev_base(2'd0, 6'h01, 16'h0005); e.fe = 1'b1; push2(e); end
        drive(1'b1, hdr(2'd0, 6'h01, 16'h0005));
        drive(1'b0, 32'd0);
        begin ev_t e; e = ev_base(2'd3, 6'h02, 16'h0007); e.ls = 1'b1; push2(e); end
        drive(1'b1, hdr(2'd3, 6'h02, 16'h0007));
        drive(1'b1, 32'hFFFF_FFFF);
        drive(1'b0, 32'd0);
        begin ev_t e; e = ev_base(2'd2, 6'h03, 16'h0007); e.le = 1'b1; push2(e); end
        drive(1'b1, hdr(2'd2, 6'h03, 16'h0007));
        drive(1'b0, 32'd0);

        // Reserved short DTs 0x04 and 0x0F: no output at all
        drive(1'b1, hdr(2'd0, 6'h04, 16'h0010));
        drive(1'b1, 32'hAAAA_AAAA);
        drive(1'b0, 32'd0);
        drive(1'b1, hdr(2'd1, 6'h0F, 16'h0020));
        drive(1'b0, 32'd0);

        // RAW8 WC=8: two full words then CRC
        drive(1'b1, hdr(2'd0, 6'h2A, 16'd8));
        push2(ev_pay(2'd0, 6'h2A, 16'd8, 32'h0302_0100, 4'hF, 1'b0));
        drive(1'b1, 32'h0302_0100);
        push2(ev_pay(2'd0, 6'h2A, 16'd8, 32'h0706_0504, 4'hF, 1'b1));
        drive(1'b1, 32'h0706_0504);
        drive(1'b1, 32'hCCCC_5555);
        drive(1'b0, 32'd0);

        // RAW10 VC=2 WC=10: F, F, 3; CRC shares the tail word then one more word
        drive(1'b1, hdr(2'd2, 6'h2B, 16'd10));
        push2(ev_pay(2'd2, 6'h2B, 16'd10, 32'h1312_1110, 4'hF, 1'b0));
        drive(1'b1, 32'h1312_1110);
        push2(ev_pay(2'd2, 6'h2B, 16'd10, 32'h1716_1514, 4'hF, 1'b0));
        drive(1'b1, 32'h1716_1514);
        push2(ev_pay(2'd2, 6'h2B, 16'd10, 32'hBEEF_1918, 4'h3, 1'b1));
        drive(1'b1, 32'hBEEF_1918);
        drive(1'b1, 32'h0000_0000);
        drive(1'b0, 32'd0);

        // Long packet WC=0: done pulse only
        begin ev_t e; e = ev_base(2'd1, 6'h2A, 16'd0); e.done = 1'b1; push2(e); end
        drive(1'b1, hdr(2'd1, 6'h2A, 16'd0));
        drive(1'b1, 32'h5A5A_5A5A);
        drive(1'b0, 32'd0);

        // WC=1 and WC=7 tails
        drive(1'b1, hdr(2'd0, 6'h2A, 16'd1));
        push2(ev_pay(2'd0, 6'h2A, 16'd1, 32'h4433_2211, 4'h1, 1'b1));
        drive(1'b1, 32'h4433_2211);
        drive(1'b0, 32'd0);
        drive(1'b1, hdr(2'd3, 6'h2B, 16'd7));
        push2(ev_pay(2'd3, 6'h2B, 16'd7, 32'hA3A2_A1A0, 4'hF, 1'b0));
        drive(1'b1, 32'hA3A2_A1A0);
        push2(ev_pay(2'd3, 6'h2B, 16'd7, 32'h77A6_A5A4, 4'h7, 1'b1));
        drive(1'b1, 32'h77A6_A5A4);
        drive(1'b0, 32'd0);

        // One ECC bit flipped: rejected with checking, decoded without
        h = hdr(2'd0, 6'h2A, 16'd4) ^ 32'h0100_0000;
        begin ev_t e; e = ev_base(2'd0, 6'h2A, 16'd4); e.ecc = 1'b1; qa.push_back(e); end
        drive(1'b1, h);
        qb.push_back(ev_pay(2'd0, 6'h2A, 16'd4, 32'hDEAD_BEEF, 4'hF, 1'b1));
        drive(1'b1, 32'hDEAD_BEEF);
        drive(1'b1, 32'h0000_1111);
        drive(1'b0, 32'd0);
        // Next good packet decodes on both
        begin ev_t e; e = ev_base(2'd1, 6'h00, 16'h0002); e.fs = 1'b1; push2(e); end
        drive(1'b1, hdr(2'd1, 6'h00, 16'h0002));
        drive(1'b0, 32'd0);

        // WC=16 truncated after two words, then an immediate new burst
        drive(1'b1, hdr(2'd0, 6'h2A, 16'd16));
        push2(ev_pay(2'd0, 6'h2A, 16'd16, 32'hB3B2_B1B0, 4'hF, 1'b0));
        drive(1'b1, 32'hB3B2_B1B0);
        push2(ev_pay(2'd0, 6'h2A, 16'd16, 32'hB7B6_B5B4, 4'hF, 1'b0));
        drive(1'b1, 32'hB7B6_B5B4);
        begin ev_t e; e = ev_base(2'd0, 6'h2A, 16'd16); e.trunc = 1'b1; push2(e); end
        drive(1'b0, 32'd0);
        begin ev_t e; e = ev_base(2'd2, 6'h03, 16'h0009); e.le = 1'b1; push2(e); end
        drive(1'b1, hdr(2'd2, 6'h03, 16'h0009));
        drive(1'b0, 32'd0);

        // Asynchronous reset mid-payload
        drive(1'b1, hdr(2'd1, 6'h2A, 16'd12));
        push2(ev_pay(2'd1, 6'h2A, 16'd12, 32'hC3C2_C1C0, 4'hF, 1'b0));
        drive(1'b1, 32'hC3C2_C1C0);
        drive(1'b1, 32'hC7C6_C5C4);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async_reset_immediate");
        lv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset_held");
        drive(1'b0, 32'd0);
        rst = 1'b0;
        begin ev_t e; e = ev_base(2'd1, 6'h02, 16'h0004); e.ls = 1'b1; push2(e); end
        drive(1'b1, hdr(2'd1, 6'h02, 16'h0004));
        drive(1'b0, 32'd0);
        drive(1'b1, hdr(2'd0, 6'h2A, 16'd4));
        push2(ev_pay(2'd0, 6'h2A, 16'd4, 32'hD3D2_D1D0, 4'hF, 1'b1));
        drive(1'b1, 32'hD3D2_D1D0);
        drive(1'b0, 32'd0);

        repeat (4) @(negedge clk);
        n_tests++;
        if (qa.size() != 0) begin
            n_fail++;
            $display("FAIL drain_A: %0d expected outputs never seen, required 0", qa.size());
        end
        n_tests++;
        if (qb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_B: %0d expected outputs never seen, required 0", qb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
